cam_pixel_capture: RTL and testbench
====================================

Name: cam_pixel_capture

Overview:
- Downstream stage of the camera interface block, which generates Xclk and presents the OV7670 Vsync/Href/Pclk/8-bit data bus.
- Oversamples the camera bus in the system clock domain and pairs bytes into RGB565 pixels.
- Emits one write per pixel with linear frame-buffer address and x/y coordinates, feeding the 640x480 image RAM.
- Frames pixels with frame start/done pulses and sticky error flags.

Parameters:
- H_ACTIVE, 640, pixels per line.
- V_ACTIVE, 480, lines per frame.
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
- SYNC_STAGES, 2, synchroniser depth applied identically to cam_pclk, cam_href, cam_vsync and cam_data (minimum 2).

Ports:
- clk  in  1  system clock; must be >= 4x Pclk frequency.
- rst_n  in  1  synchronous active-low reset.
- cap_en  in  1  arm capture; sampled only at frame start.
- cam_pclk  in  1  camera pixel clock (asynchronous).
- cam_href  in  1  line valid, active high.
- cam_vsync  in  1  frame sync, high during vertical blanking.
- cam_data  in  8  camera byte bus.
- pix_valid  out  1  one-cycle write strobe.
- pix_data  out  16  RGB565 pixel: first byte in [15:8], second byte in [7:0].
- pix_addr  out  ADDR_W  linear address y*H_ACTIVE+x.
- pix_x  out  10  column of the current pixel.
- pix_y  out  9  row of the current pixel.
- frame_start  out  1  one-cycle pulse.
- frame_done  out  1  one-cycle pulse.
- busy  out  1  high in state FRAME.
- err  out  2  sticky error flags: [0] overflow, [1] odd byte count.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, all counters 0, byte phase 0, FSM in IDLE, synchroniser and edge-detect registers cleared.
- Reset mid-frame aborts the frame. No frame_done is issued. The FSM waits for a full Vsync high-to-low transition before capturing again.
- Synchronisation and edge detection:
  - All four camera inputs pass through the same SYNC_STAGES flops, so they stay mutually aligned.
  - A Pclk rise is detected as the synced value being 1 now and 0 in the previous cycle.
  - Data and Href are taken from the synced copies in the same cycle as the detected rise.
  - Vsync and Href edges are detected the same way.
- FSM states:
  - IDLE to WAIT_VS: after reset.
  - WAIT_VS to FRAME: on a Vsync fall with cap_en=1. Pulse frame_start, clear err, x=y=0, addr=0.
  - WAIT_VS stays in WAIT_VS: on a Vsync fall with cap_en=0.
  - FRAME to WAIT_VS: on a Vsync rise. Pulse frame_done in the same cycle.
  - Deasserting cap_en inside FRAME does not abort; the current frame completes.
- Byte pairing in FRAME, on each Pclk rise with Href=1:
  - phase 0: store the byte as the high byte and set phase to 1.
  - phase 1: form the pixel, set phase to 0, then issue the write.
- Write issue:
  - Applies when x < H_ACTIVE and y < V_ACTIVE.
  - pix_valid=1 for exactly one cycle, with pix_data, pix_addr, pix_x and pix_y all valid in that cycle.
  - Afterwards x and addr increment.
  - Latency: pix_valid rises SYNC_STAGES+2 clk cycles after the first clk edge that samples cam_pclk high for the second byte.
- Overflow: a pixel with x >= H_ACTIVE or y >= V_ACTIVE is dropped, no write is issued, and err[0] is set.
- Href fall:
  - If phase is 1, the dangling byte is dropped and err[1] is set.
  - phase resets to 0 and x resets to 0.
  - y increments only if the line produced at least one pixel.
  - addr does not wrap; it continues linearly from the last write.
- Simultaneous events:
  - Vsync rise together with a pending pixel: the pixel is written first, and frame_done follows in the next cycle.
  - Href fall together with the second-byte Pclk rise: the pixel is completed first, then the line-end processing runs.
- err bits hold until the next frame_start or reset.
- pix_addr never exceeds H_ACTIVE*V_ACTIVE-1.

Optional Feature:
- Macro: CAP_DECIMATE2_EN.
- When defined:
  - Output is 2x2 decimated (QVGA): only even-x pixels on even-y lines are written.
  - pix_x and pix_y carry the decimated coordinates.
  - pix_addr = (y/2)*(H_ACTIVE/2)+(x/2).
  - Overflow checks use the full-resolution counters.
- When undefined: full-resolution capture exactly as specified above.

Decomposition:
- Shared package cam_pkg holds:
  - constants H_ACTIVE_DEF=640, V_ACTIVE_DEF=480;
  - FSM state enum cap_state_t {IDLE, WAIT_VS, FRAME};
  - err bit indices ERR_OVF=0, ERR_ODD=1;
  - RGB565 field slice constants.
- Sub-module cam_sync_edge: SYNC_STAGES-deep synchroniser plus rise/fall detect. Instantiated once over the 11-bit bundle {pclk, href, vsync, data}.

Test Plan:
- Vsync fall with cap_en=1, 2 lines of 4 bytes (A1,B2,C3,D4), Href low between lines, then Vsync rise:
  - 4 writes: data 0xA1B2 at addr 0 (x0,y0); 0xC3D4 at addr 1 (x1,y0); 0xA1B2 at addr 640 (x0,y1); 0xC3D4 at addr 641 (x1,y1).
  - frame_start and frame_done each pulse once; err=00.
- Line of 3 bytes: 1 write, err[1]=1; the next line's first pixel is at x=0 using the correct byte pairing.
- Line of 1282 bytes with H_ACTIVE=640: 640 writes, the 641st pixel is dropped, err[0]=1, last addr on that line is 639.
- cap_en=0 at the Vsync fall: no pix_valid and no frame_start for the whole frame. cap_en=1 at the next Vsync fall: capture resumes at addr 0.
- rst_n pulled low mid-line for 1 cycle: all outputs are 0 next cycle; no writes until a fresh Vsync fall; the next frame starts at addr 0.
- With CAP_DECIMATE2_EN, 4 lines of 8 pixels: 8 writes at addr 0..3 and 320..323.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 pixel capture path.
//   H_ACTIVE_DEF / V_ACTIVE_DEF : default VGA frame geometry
//   cap_state_t                 : capture FSM states
//   ERR_OVF / ERR_ODD           : bit positions inside the sticky err vector
//   PIX_* slices, rgb565_t      : RGB565 word layout (first camera byte is the high byte)
package cam_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    FRAME   = 2'd2
  } cap_state_t;

  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_ODD = 1;

  localparam int unsigned PIX_HI_MSB = 15;
  localparam int unsigned PIX_HI_LSB = 8;
  localparam int unsigned PIX_LO_MSB = 7;
  localparam int unsigned PIX_LO_LSB = 0;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  function automatic logic [15:0] rgb565_pack(input logic [7:0] hi, input logic [7:0] lo);
    logic [15:0] word;
    word = '0;
    word[PIX_HI_MSB:PIX_HI_LSB] = hi;
    word[PIX_LO_MSB:PIX_LO_LSB] = lo;
    return word;
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Multi-flop synchroniser with registered rise/fall detection.
// Every bit of the bundle goes through the same depth, so related camera signals stay aligned.
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   din_i      : asynchronous input bundle
//   level_o    : synchronised level, aligned with rise_o/fall_o
//   rise_o     : one-cycle pulse when the synchronised bit went 0 -> 1
//   fall_o     : one-cycle pulse when the synchronised bit went 1 -> 0
module cam_sync_edge #(
  parameter int unsigned WIDTH  = 11,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  if (STAGES < 2) begin : gen_depth_check
    $error("cam_sync_edge: STAGES must be at least 2");
  end

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync_q[0] <= din_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
      prev_q <= sync_q[STAGES-1];
    end
  end

  // prev_q holds the same sample the edge flags were computed from.
  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/cam_pixel_capture.sv
// OV7670 pixel capture: oversamples Pclk/Href/Vsync/data in the clk domain, pairs bytes into
// RGB565 pixels and emits one frame-buffer write per pixel with linear address and x/y.
// Optional build macro CAP_DECIMATE2_EN: 2x2 decimation (only even x on even y written,
// decimated coordinates and address).
// Ports:
//   clk, rst_n                : system clock (>= 4x Pclk), synchronous active-low reset
//   cap_en                    : arm capture, sampled at the Vsync fall
//   cam_pclk/href/vsync/data  : asynchronous camera bus
//   pix_valid                 : one-cycle write strobe qualifying pix_data/addr/x/y
//   frame_start, frame_done   : one-cycle frame pulses
//   busy                      : high while capturing a frame
//   err                       : sticky [0] overflow, [1] odd byte count; cleared at frame_start
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_en,
  input  logic              cam_pclk,
  input  logic              cam_href,
  input  logic              cam_vsync,
  input  logic [7:0]        cam_data,
  output logic              pix_valid,
  output logic [15:0]       pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [9:0]        pix_x,
  output logic [8:0]        pix_y,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy,
  output logic [1:0]        err
);

  localparam logic [9:0] XLim = 10'(H_ACTIVE);
  localparam logic [8:0] YLim = 9'(V_ACTIVE);
`ifdef CAP_DECIMATE2_EN
  localparam logic [ADDR_W-1:0] LineStep = ADDR_W'(H_ACTIVE / 2);
`else
  localparam logic [ADDR_W-1:0] LineStep = ADDR_W'(H_ACTIVE);
`endif

  // Bundle layout: [10] pclk, [9] href, [8] vsync, [7:0] data.
  logic [10:0] lvl, rise, fall;

  cam_sync_edge #(
    .WIDTH  (11),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .din_i   ({cam_pclk, cam_href, cam_vsync, cam_data}),
    .level_o (lvl),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  logic       pclk_rise, href_lvl, href_fall, vs_rise, vs_fall;
  logic [7:0] cam_byte;
  logic       unused_edges;
  assign pclk_rise    = rise[10];
  assign href_lvl     = lvl[9];
  assign href_fall    = fall[9];
  assign vs_rise      = rise[8];
  assign vs_fall      = fall[8];
  assign cam_byte     = lvl[7:0];
  assign unused_edges = ^{rise[9], rise[7:0], fall[10], fall[7:0], lvl[10], lvl[8]};

  // Pairing stage: byte phase, completed pixel and events delayed to line up with it.
  logic        phase_q, phase_d, pend_q, pend_d, odd_q, odd_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] word_q, word_d;
  logic        hfall_q, vrise_q, vfall_q;

  // Write stage: FSM, counters and registered outputs.
  cap_state_t        state_q, state_d;
  logic [9:0]        x_q, x_d, pix_x_q, pix_x_d;
  logic [8:0]        y_q, y_d, pix_y_q, pix_y_d;
  logic [ADDR_W-1:0] base_q, base_d, pix_addr_q, pix_addr_d;
  logic              line_pix_q, line_pix_d, done_defer_q, done_defer_d;
  logic [1:0]        err_q, err_d;
  logic              pix_valid_q, pix_valid_d, fstart_q, fstart_d, fdone_q, fdone_d;
  logic [15:0]       pix_data_q, pix_data_d;

  always_comb begin
    phase_d = phase_q;
    hi_d    = hi_q;
    word_d  = word_q;
    pend_d  = 1'b0;
    odd_d   = 1'b0;
    if (state_q == FRAME) begin
      // A byte coinciding with the Href fall still belongs to the line.
      if (pclk_rise && (href_lvl || href_fall)) begin
        if (!phase_q) begin
          hi_d    = cam_byte;
          phase_d = 1'b1;
        end else begin
          word_d  = rgb565_pack(hi_q, cam_byte);
          pend_d  = 1'b1;
          phase_d = 1'b0;
        end
      end
      if (href_fall) begin
        odd_d   = phase_d;
        phase_d = 1'b0;
      end
    end else begin
      phase_d = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    base_d       = base_q;
    line_pix_d   = line_pix_q;
    err_d        = err_q;
    done_defer_d = 1'b0;
    pix_valid_d  = 1'b0;
    pix_data_d   = pix_data_q;
    pix_addr_d   = pix_addr_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    fstart_d     = 1'b0;
    fdone_d      = done_defer_q;
    unique case (state_q)
      IDLE: state_d = WAIT_VS;
      WAIT_VS: begin
        if (vfall_q && cap_en) begin
          state_d    = FRAME;
          fstart_d   = 1'b1;
          err_d      = '0;
          x_d        = '0;
          y_d        = '0;
          base_d     = '0;
          line_pix_d = 1'b0;
        end
      end
      FRAME: begin
        // Pending pixel is handled before line-end and frame-end processing.
        if (pend_q) begin
          line_pix_d = 1'b1;
          if ((x_q < XLim) && (y_q < YLim)) begin
            x_d = x_q + 10'd1;
`ifdef CAP_DECIMATE2_EN
            if (!x_q[0] && !y_q[0]) begin
              pix_valid_d = 1'b1;
              pix_data_d  = word_q;
              pix_x_d     = {1'b0, x_q[9:1]};
              pix_y_d     = {1'b0, y_q[8:1]};
              pix_addr_d  = base_q + ADDR_W'(x_q[9:1]);
            end
`else
            pix_valid_d = 1'b1;
            pix_data_d  = word_q;
            pix_x_d     = x_q;
            pix_y_d     = y_q;
            pix_addr_d  = base_q + ADDR_W'(x_q);
`endif
          end else begin
            err_d[ERR_OVF] = 1'b1;
          end
        end
        if (odd_q) err_d[ERR_ODD] = 1'b1;
        if (hfall_q) begin
          x_d = '0;
          // Saturating y keeps the overflow check valid and the address in range.
          if (line_pix_d && (y_q < YLim)) begin
            y_d = y_q + 9'd1;
`ifdef CAP_DECIMATE2_EN
            if (y_q[0]) base_d = base_q + LineStep;
`else
            base_d = base_q + LineStep;
`endif
          end
          line_pix_d = 1'b0;
        end
        if (vrise_q) begin
          state_d = WAIT_VS;
          if (pend_q) done_defer_d = 1'b1;
          else        fdone_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q      <= 1'b0;
      hi_q         <= '0;
      word_q       <= '0;
      pend_q       <= 1'b0;
      odd_q        <= 1'b0;
      hfall_q      <= 1'b0;
      vrise_q      <= 1'b0;
      vfall_q      <= 1'b0;
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      base_q       <= '0;
      line_pix_q   <= 1'b0;
      err_q        <= '0;
      done_defer_q <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_addr_q   <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      fstart_q     <= 1'b0;
      fdone_q      <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      word_q       <= word_d;
      pend_q       <= pend_d;
      odd_q        <= odd_d;
      hfall_q      <= href_fall;
      vrise_q      <= vs_rise;
      vfall_q      <= vs_fall;
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      base_q       <= base_d;
      line_pix_q   <= line_pix_d;
      err_q        <= err_d;
      done_defer_q <= done_defer_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      pix_addr_q   <= pix_addr_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      fstart_q     <= fstart_d;
      fdone_q      <= fdone_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign pix_addr    = pix_addr_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = fstart_q;
  assign frame_done  = fdone_q;
  assign busy        = (state_q == FRAME);
  assign err         = err_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Scoreboard bench for cam_pixel_capture (default build, 640x480, SYNC_STAGES=2).
module tb_cam_pixel_capture;

  localparam int unsigned AW = 19;
  localparam int unsigned SS = 2;

  logic          clk = 1'b0;
  logic          rst_n, cap_en, cam_pclk, cam_href, cam_vsync;
  logic [7:0]    cam_data;
  logic          pix_valid, frame_start, frame_done, busy;
  logic [15:0]   pix_data;
  logic [AW-1:0] pix_addr;
  logic [9:0]    pix_x;
  logic [8:0]    pix_y;
  logic [1:0]    err;

  cam_pixel_capture #(
    .H_ACTIVE    (640),
    .V_ACTIVE    (480),
    .ADDR_W      (AW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cap_en      (cap_en),
    .cam_pclk    (cam_pclk),
    .cam_href    (cam_href),
    .cam_vsync   (cam_vsync),
    .cam_data    (cam_data),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_addr    (pix_addr),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]   data;
    logic [AW-1:0] addr;
    logic [9:0]    x;
    logic [8:0]    y;
  } pix_t;

  pix_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   fs_cnt   = 0;
  int   fd_cnt   = 0;
  logic [AW-1:0] last_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Monitor: pops one expectation per write strobe.
  always @(negedge clk) begin
    if (frame_start) fs_cnt++;
    if (frame_done) fd_cnt++;
    if (pix_valid) begin
      last_addr = pix_addr;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                 pix_addr, pix_data);
      end else begin
        automatic pix_t e = exp_q.pop_front();
        check("pix_data", 32'(pix_data), 32'(e.data));
        check("pix_addr", 32'(pix_addr), 32'(e.addr));
        check("pix_x", 32'(pix_x), 32'(e.x));
        check("pix_y", 32'(pix_y), 32'(e.y));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pix(input logic [15:0] d, input int a, input int x, input int y);
    exp_q.push_back('{data: d, addr: AW'(a), x: 10'(x), y: 9'(y)});
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_pclk = 1'b0;
    cam_data = b;
    tick(2);
    cam_pclk = 1'b1;
    tick(2);
  endtask

  task automatic line_begin();
    cam_href = 1'b1;
    tick(2);
  endtask

  task automatic line_end();
    cam_pclk = 1'b0;
    tick(2);
    cam_href = 1'b0;
    tick(10);
  endtask

  task automatic frame_begin();
    cam_vsync = 1'b1;
    tick(6);
    cam_vsync = 1'b0;
    tick(8);
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1;
    tick(10);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      tick(1);
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_pix_data"}, 32'(pix_data), 32'd0);
    check({tag, "_pix_addr"}, 32'(pix_addr), 32'd0);
    check({tag, "_pix_x"}, 32'(pix_x), 32'd0);
    check({tag, "_pix_y"}, 32'(pix_y), 32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0; cap_en = 1'b0; cam_pclk = 1'b0; cam_href = 1'b0;
    cam_vsync = 1'b0; cam_data = 8'h00;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(3);
    check("idle_busy", 32'(busy), 32'd0);

    // Two lines of A1 B2 C3 D4; cap_en dropped mid-frame must not abort.
    cap_en = 1'b1;
    frame_begin();
    check("t1_fs", 32'(fs_cnt), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    cap_en = 1'b0;
    expect_pix(16'hA1B2, 0, 0, 0);
    expect_pix(16'hC3D4, 1, 1, 0);
    line_begin();
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
    line_end();
    expect_pix(16'hA1B2, 640, 0, 1);
    expect_pix(16'hC3D4, 641, 1, 1);
    line_begin();
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
    line_end();
    frame_end();
    drain("t1_drain");
    check("t1_fd", 32'(fd_cnt), 32'd1);
    check("t1_fs_once", 32'(fs_cnt), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);

    // Odd line: dangling byte flagged, next line pairs cleanly from x=0.
    cap_en = 1'b1;
    frame_begin();
    expect_pix(16'hA1B2, 0, 0, 0);
    line_begin();
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
    line_end();
    expect_pix(16'h5566, 640, 0, 1);
    line_begin();
    send_byte(8'h55); send_byte(8'h66);
    line_end();
    frame_end();
    drain("t2_drain");
    check("t2_err", 32'(err), 32'd2);
    check("t2_fd", 32'(fd_cnt), 32'd2);

    // 1282-byte line: 640 writes, pixel 641 dropped with overflow.
    frame_begin();
    for (int i = 0; i < 640; i++) expect_pix({8'(i), ~8'(i)}, i, i, 0);
    line_begin();
    for (int i = 0; i < 641; i++) begin
      send_byte(8'(i));
      send_byte(~8'(i));
    end
    line_end();
    frame_end();
    drain("t3_drain");
    check("t3_last_addr", 32'(last_addr), 32'd639);
    check("t3_err", 32'(err), 32'd1);

    // cap_en low at the Vsync fall: whole frame ignored, err held.
    cap_en = 1'b0;
    frame_begin();
    line_begin();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    line_end();
    frame_end();
    check("t4_fs_skip", 32'(fs_cnt), 32'd3);
    check("t4_fd_skip", 32'(fd_cnt), 32'd3);
    check("t4_err_hold", 32'(err), 32'd1);
    cap_en = 1'b1;
    frame_begin();
    check("t4_fs_resume", 32'(fs_cnt), 32'd4);
    expect_pix(16'h1234, 0, 0, 0);
    line_begin();
    send_byte(8'h12); send_byte(8'h34);
    line_end();
    frame_end();
    drain("t4_drain");
    check("t4_err_clr", 32'(err), 32'd0);
    check("t4_fd", 32'(fd_cnt), 32'd4);

    // Latency, then reset mid-line.
    frame_begin();
    line_begin();
    send_byte(8'h9A);
    cam_pclk = 1'b0;
    cam_data = 8'hBC;
    tick(2);
    expect_pix(16'h9ABC, 0, 0, 0);
    cam_pclk = 1'b1;
    // k=1 is the first edge sampling Pclk high; the strobe rises SS+2 edges after it.
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (pix_valid && lat == 0) lat = k;
    end
    check("t5_latency", 32'(lat), 32'(SS + 3));
    expect_pix(16'hC3D4, 1, 1, 0);
    send_byte(8'hC3); send_byte(8'hD4); send_byte(8'h77);
    drain("t5_pre_drain");
    check("t5_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick(1);
    check_all_zero("t5_rst");
    rst_n = 1'b1;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    line_end();
    frame_end();
    check("t5_no_done", 32'(fd_cnt), 32'd4);
    check("t5_no_start", 32'(fs_cnt), 32'd5);
    frame_begin();
    check("t5_fs_fresh", 32'(fs_cnt), 32'd6);
    expect_pix(16'h5566, 0, 0, 0);
    line_begin();
    send_byte(8'h55); send_byte(8'h66);
    line_end();
    frame_end();
    drain("t5_drain");
    check("t5_fd", 32'(fd_cnt), 32'd5);
    check("t5_err", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
